// File: rtl/rx_buffer_pkg.sv
// Shared types and defaults for the multichannel receive buffer.
// Holds the serialiser state encoding and a constant-foldable log2 helper.
package rx_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    SER  = 2'd2
  } rx_state_e;

  localparam int          DEF_WIDTH        = 16;
  localparam int          DEF_MAX_CH       = 8;
  localparam int          DEF_DEPTH        = 1024;
  localparam int          DEF_PACKET_WORDS = 256;
  localparam logic [15:0] DEF_HEADER_WORD  = 16'hA5A5;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/rx_buf_ram.sv
// Simple dual-port buffer RAM, one write port and one registered read port.
// The read register holds its value until the next read enable.
module rx_buf_ram
  import rx_buffer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rd_data_r;

  // Storage array write port; contents are not reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port, cleared by reset and held between reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_r <= {WIDTH{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/rx_chan_buffer.sv
// Multichannel receive buffer: snapshots a sample set per strobe, serialises
// the active channels (optionally behind a header) into a circular buffer.
module rx_chan_buffer
  import rx_buffer_pkg::*;
#(
  parameter int               WIDTH        = DEF_WIDTH,
  parameter int               MAX_CH       = DEF_MAX_CH,
  parameter int               DEPTH        = DEF_DEPTH,
  parameter int               PACKET_WORDS = DEF_PACKET_WORDS,
  parameter logic [WIDTH-1:0] HEADER_WORD  = WIDTH'(DEF_HEADER_WORD)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [$clog2(MAX_CH):0]   channels,
  input  logic [MAX_CH*WIDTH-1:0]   din,
  input  logic                      strobe,
  input  logic                      gate,
  input  logic                      header_en,
  input  logic                      rd_req,
  input  logic                      clear_status,
  output logic [WIDTH-1:0]          dout,
  output logic                      dout_valid,
  output logic                      packet_rdy,
  output logic [$clog2(DEPTH):0]    fill_count,
  output logic                      overflow,
  output logic                      underrun
);

  localparam int CH_W  = clog2(MAX_CH) + 1;
  localparam int CNT_W = clog2(DEPTH) + 1;
  localparam int AW    = clog2(DEPTH);
  localparam int IDX_W = (MAX_CH > 1) ? clog2(MAX_CH) : 1;

  rx_state_e        state_r;
  rx_state_e        state_nxt_s;
  logic             gate_r;
  logic             gate_prev_r;
  logic             header_pending_r;
  logic [CH_W-1:0]  ch_eff_s;
  logic [CH_W-1:0]  ch_cnt_r;
  logic [IDX_W-1:0] idx_r;
  logic [WIDTH-1:0] shadow_r [MAX_CH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CNT_W-1:0] fill_r;
  logic [CNT_W-1:0] need_s;
  logic [CNT_W-1:0] space_s;
  logic             strobe_live_s;
  logic             accept_s;
  logic             drop_s;
  logic             ser_last_s;
  logic             wr_en_s;
  logic [WIDTH-1:0] wr_data_s;
  logic             rd_ok_s;
  logic             rd_empty_s;
  logic             overflow_r;
  logic             underrun_r;
  logic             dout_valid_r;
  logic [WIDTH-1:0] ram_q_s;

  // Clamp the requested channel count to what the shadow bank can hold.
  always_comb begin
    if (channels > CH_W'(MAX_CH)) begin
      ch_eff_s = CH_W'(MAX_CH);
    end else begin
      ch_eff_s = channels;
    end
  end

  // Space is reserved for the whole set at accept time, so serialisation never stalls.
  assign need_s        = CNT_W'(ch_eff_s) + CNT_W'(header_pending_r);
  assign space_s       = CNT_W'(DEPTH) - fill_r;
  assign strobe_live_s = strobe & gate_r & (ch_eff_s != {CH_W{1'b0}});
  assign accept_s      = strobe_live_s & (state_r == IDLE) & (space_s >= need_s);
  assign drop_s        = strobe_live_s & ~accept_s;
  assign ser_last_s    = (CH_W'(idx_r) == (ch_cnt_r - CH_W'(1)));
  assign rd_ok_s       = rd_req & (fill_r != {CNT_W{1'b0}});
  assign rd_empty_s    = rd_req & (fill_r == {CNT_W{1'b0}});

  // Serialiser state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Serialiser next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = header_pending_r ? HDR : SER;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HDR: state_nxt_s = SER;
      SER: begin
        if (ser_last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SER;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Serialiser outputs: one buffer write per HDR/SER cycle.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_data_s = {WIDTH{1'b0}};
    case (state_r)
      HDR: begin
        wr_en_s   = 1'b1;
        wr_data_s = HEADER_WORD;
      end
      SER: begin
        wr_en_s   = 1'b1;
        wr_data_s = shadow_r[idx_r];
      end
      default: begin
        wr_en_s   = 1'b0;
        wr_data_s = {WIDTH{1'b0}};
      end
    endcase
  end

  // Gate edge detect, header request, sample snapshot and serialiser index.
  always_ff @(posedge clock) begin
    if (reset) begin
      gate_r           <= 1'b0;
      gate_prev_r      <= 1'b0;
      header_pending_r <= 1'b0;
      ch_cnt_r         <= {CH_W{1'b0}};
      idx_r            <= {IDX_W{1'b0}};
      for (int k = 0; k < MAX_CH; k++) begin
        shadow_r[k] <= {WIDTH{1'b0}};
      end
    end else begin
      gate_r      <= gate;
      gate_prev_r <= gate_r;
      if (gate_r & ~gate_prev_r & header_en) begin
        header_pending_r <= 1'b1;
      end else if (state_r == HDR) begin
        header_pending_r <= 1'b0;
      end
      if (accept_s) begin
        ch_cnt_r <= ch_eff_s;
        for (int k = 0; k < MAX_CH; k++) begin
          shadow_r[k] <= din[k*WIDTH +: WIDTH];
        end
      end
      if ((state_r == SER) && !ser_last_s) begin
        idx_r <= idx_r + IDX_W'(1);
      end else begin
        idx_r <= {IDX_W{1'b0}};
      end
    end
  end

  // Circular buffer pointers and occupancy; pointers wrap at DEPTH naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      fill_r   <= {CNT_W{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({wr_en_s, rd_ok_s})
        2'b10:   fill_r <= fill_r + CNT_W'(1);
        2'b01:   fill_r <= fill_r - CNT_W'(1);
        default: fill_r <= fill_r;
      endcase
    end
  end

  // Sticky status flags (a new event beats clear) and read-valid strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_r   <= 1'b0;
      underrun_r   <= 1'b0;
      dout_valid_r <= 1'b0;
    end else begin
      overflow_r   <= drop_s | (overflow_r & ~clear_status);
      underrun_r   <= rd_empty_s | (underrun_r & ~clear_status);
      dout_valid_r <= rd_ok_s;
    end
  end

  rx_buf_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en_s),
    .wr_addr (wr_ptr_r),
    .wr_data (wr_data_s),
    .rd_en   (rd_ok_s),
    .rd_addr (rd_ptr_r),
    .rd_data (ram_q_s)
  );

  assign dout       = ram_q_s;
  assign dout_valid = dout_valid_r;
  assign fill_count = fill_r;
  assign overflow   = overflow_r;
  assign underrun   = underrun_r;
  assign packet_rdy = (fill_r >= CNT_W'(PACKET_WORDS));

endmodule

// File: doc/rx_chan_buffer.md
Name: rx_chan_buffer

Overview:
Single-clock, parametrised multichannel receive buffer and successor to the fixed 8-channel rx FIFO.
- On each decimated strobe it snapshots up to MAX_CH channel samples and serialises the active ones into a circular buffer. Each sample set is written atomically.
- It can optionally prefix a header word at each gate rising edge.
- The read side drains the buffer word by word toward the USB packetiser.
- It reports packet readiness, fill level, and sticky overflow/underrun status.

Parameters:
- WIDTH, 16, sample and word width in bits.
- MAX_CH, 8, maximum channel count (>=1).
- DEPTH, 1024, buffer depth in words; power of 2, >= 2*MAX_CH.
- PACKET_WORDS, 256, packet_rdy threshold in words; must be <= DEPTH.
- HEADER_WORD, 16'hA5A5, header value; WIDTH bits.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- channels  in  $clog2(MAX_CH)+1  active channel count.
- din  in  MAX_CH*WIDTH  channel k occupies [k*WIDTH +: WIDTH].
- strobe  in  1  sample-set valid, one-cycle pulse.
- gate  in  1  receive window.
- header_en  in  1  enables header insertion.
- rd_req  in  1  read request.
- clear_status  in  1  clears sticky flags.
- dout  out  WIDTH  read data.
- dout_valid  out  1  dout holds a newly read word.
- packet_rdy  out  1  fill_count >= PACKET_WORDS.
- fill_count  out  $clog2(DEPTH)+1  words stored.
- overflow  out  1  sticky; a sample set was dropped.
- underrun  out  1  sticky; rd_req was issued while empty.

Behaviour:
- Reset (synchronous) clears pointers, fill_count, FSM, header_pending, shadow registers, dout, dout_valid, overflow and underrun, all to 0. Reset mid-serialisation abandons the set; no partial data remains.
- Effective channel count: ch_eff = min(channels, MAX_CH). When channels==0, strobes are ignored with no flag set.
- gate is registered once. A rising edge of the registered gate with header_en=1 sets header_pending. Strobes arriving while registered gate=0 are ignored.
- Accept rule, evaluated in the strobe cycle with FSM in IDLE:
  - need = ch_eff + header_pending.
  - If DEPTH - fill_count >= need: snapshot din into shadow registers and go to HDR (if header_pending) or SER.
  - Otherwise drop the whole set and set overflow. header_pending stays set.
- A strobe arriving while the FSM is not IDLE drops that set and sets overflow. The in-progress set is unaffected.
- FSM states:
  - IDLE.
  - HDR: write HEADER_WORD, clear header_pending, go to SER.
  - SER: write shadow[idx], idx 0..ch_eff-1, one word per cycle; after the last word go to IDLE.
- Latency: the first word of a set is in the RAM and counted in fill_count at strobe+2.
- Read:
  - rd_req with fill_count>0 returns dout = word at rd_ptr on the next cycle, with dout_valid=1 for exactly that cycle.
  - rd_req with fill_count==0 is ignored and sets underrun. dout holds its last value and dout_valid=0.
- Pointers wrap modulo DEPTH.
- A write and a read in the same cycle leave fill_count unchanged. A read from a full buffer in the same cycle as a write is legal, since the accept check already reserved the space.
- Full/empty boundaries: fill_count == DEPTH is full; 0 is empty.
- packet_rdy is combinational from the registered fill_count.
- clear_status clears overflow and underrun. If a new overflow or underrun event occurs in the same cycle, the flag is set (set wins).

Decomposition:
- Package rx_buffer_pkg holds:
  - FSM state enum (IDLE, HDR, SER).
  - Helper function clog2.
  - Default constants for WIDTH, MAX_CH, DEPTH and HEADER_WORD.
- One sub-module, rx_buf_ram: single-clock simple dual-port RAM, DEPTH x WIDTH, registered read port. The write/read pointers, fill counter and FSM stay in rx_chan_buffer.

Test Plan:
- Set of 4 channels, strobe with din0..3 = 1,2,3,4, gate=1, header_en=0 → fill_count reaches 4 by strobe+5. Reads return 1,2,3,4, each with dout_valid.
- header_en=1 with a gate rising edge, then channels=2, strobe with 7,8 → reads return A5A5,7,8. A second strobe in the same gate produces no header.
- DEPTH=16, channels=4, fill to 14, then strobe → set dropped, overflow=1, fill_count stays 14. clear_status → overflow=0.
- Strobes 2 cycles apart with channels=4 → the second set is dropped and overflow=1. The first set is intact.
- rd_req while empty → underrun=1, dout_valid=0. Also assert reset mid-SER → fill_count=0 on the next cycle and no stray words are read afterwards.
- PACKET_WORDS=8, write 8 words with a simultaneous continuous read → packet_rdy tracks fill_count >= 8 exactly. Pointer wrap verified after 3*DEPTH words with data intact.
